// File: rtl/uart_tx_buffered.sv
// Self-timed 8N1 UART transmitter with a small circular input FIFO.
// Bytes are accepted on valid/ready and sent LSB first, back-to-back when queued.
module uart_tx_buffered #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic                          tx,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int CPB = CLK_FREQ / BAUD;
    localparam int BW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          ready_q;
    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d, busy_q, busy_d, done_q, done_d;
    logic          push_s, pop_s, baud_last_s;

    assign push_s       = i_valid && ready_q;
    assign baud_last_s  = (baud_q == BAUD_LAST);
    assign o_ready      = ready_q;
    assign tx           = tx_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_fifo_count = count_q;

    // FIFO occupancy after this edge's push/pop
    always_comb begin
        count_d = count_q;
        if (push_s && !pop_s) begin
            count_d = count_q + CW'(1);
        end else if (!push_s && pop_s) begin
            count_d = count_q - CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // FIFO storage; full-state writes never reach here because push needs ready
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    // FIFO pointers, count and ready flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            if (push_s) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_s)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            ready_q <= (count_d != FULL);
        end
    end

    // Frame sequencer: baud counter wraps every bit, bit_q counts data then stop bits
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop_s   = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    state_d = S_START;
                end else begin
                    baud_d = '0;
                end
            end
            S_START: begin
                if (baud_last_s) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_DATA: begin
                if (baud_last_s) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_STOP: begin
                if (baud_last_s) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d = 3'd0;
                        if (count_q != '0) begin
                            pop_s   = 1'b1;
                            shift_d = mem_q[rd_ptr_q];
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                bit_d   = 3'd0;
            end
        endcase
    end

    // Line outputs follow the sequencer state by one register stage
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_q != S_IDLE);
        done_d = (state_q == S_STOP) && baud_last_s && (bit_q == STOP_LAST);
        case (state_q)
            S_IDLE:  tx_d = 1'b1;
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_q[0];
            S_STOP:  tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    // Sequencer and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule
